// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin byte arbiter with per-message lock driving an 8N1 serializer
module serial_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int OWNW      = 2,
  parameter int BAUD_DIV  = 434,
  parameter int STOP_BITS = 1,
  parameter int LOCK_TMO  = 65535
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              tx,
  output logic              busy,
  output logic              locked,
  output logic [OWNW-1:0]   owner,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] TMO_LAST  = 16'((LOCK_TMO == 0) ? 0 : LOCK_TMO - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_t          state, state_n;
  logic [15:0]     baud_cnt, baud_cnt_n;
  logic [15:0]     idle_cnt, idle_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift_reg, shift_n;
  logic [OWNW-1:0] rr_ptr, rr_n, owner_n;
  logic [OWNW-1:0] scan_idx, scan_win, win;
  logic            scan_found, grant, baud_wrap;
  logic            locked_n, tx_n, busy_n, done_n;
  logic [NREQ-1:0] ack_n;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    scan_found = 1'b0;
    scan_win   = rr_ptr;
    scan_idx   = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = rr_ptr + OWNW'(i);
      if (!scan_found && req_valid[scan_idx]) begin
        scan_found = 1'b1;
        scan_win   = scan_idx;
      end
    end
  end

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    idle_cnt_n = idle_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift_reg;
    rr_n       = rr_ptr;
    owner_n    = owner;
    locked_n   = locked;
    ack_n      = '0;
    tx_n       = 1'b1;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    grant      = 1'b0;
    win        = scan_win;

    case (state)
      IDLE: begin
        if (locked) begin
          win = owner;
          if (req_valid[owner]) begin
            grant = 1'b1;
          end else if (LOCK_TMO != 0) begin
            if (idle_cnt == TMO_LAST) begin
              locked_n   = 1'b0;
              idle_cnt_n = '0;
            end else begin
              idle_cnt_n = idle_cnt + 16'd1;
            end
          end
        end else begin
          grant = scan_found;
        end
        if (grant) begin
          ack_n      = NREQ'(1) << win;
          shift_n    = req_data[win*8 +: 8];
          owner_n    = win;
          locked_n   = ~req_last[win];
          rr_n       = win + OWNW'(1);
          idle_cnt_n = '0;
          baud_cnt_n = '0;
          state_n    = START;
        end
      end
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
        baud_cnt_n = baud_wrap ? 16'd0 : baud_cnt + 16'd1;
        if (baud_wrap) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        tx_n   = shift_reg[0];
        busy_n = 1'b1;
        baud_cnt_n = baud_wrap ? 16'd0 : baud_cnt + 16'd1;
        if (baud_wrap) begin
          shift_n = shift_reg >> 1;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        busy_n = 1'b1;
        baud_cnt_n = baud_wrap ? 16'd0 : baud_cnt + 16'd1;
        if (baud_wrap) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            done_n    = 1'b1;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line outputs trail the state by one cycle so tx, busy and frame_done come straight from flops.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      idle_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rr_ptr     <= '0;
      owner      <= '0;
      locked     <= 1'b0;
      req_ack    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      idle_cnt   <= idle_cnt_n;
      bit_idx    <= bit_idx_n;
      shift_reg  <= shift_n;
      rr_ptr     <= rr_n;
      owner      <= owner_n;
      locked     <= locked_n;
      req_ack    <= ack_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - bench for serial_tx_arbiter with a queue-based arbitration model
module tb_serial_tx_arbiter;
  localparam int NREQ      = 4;
  localparam int OWNW      = 2;
  localparam int BAUD_DIV  = 4;
  localparam int STOP_BITS = 1;
  localparam int LOCK_TMO  = 16;
  localparam int NBITS     = 9 + STOP_BITS;
  localparam int FRAME     = NBITS * BAUD_DIV;

  logic              clk100 = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_last, req_ack;
  logic [8*NREQ-1:0] req_data;
  logic              tx, busy, locked, frame_done;
  logic [OWNW-1:0]   owner;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [8:0]       q  [NREQ][$];
  logic [8:0]       mq [NREQ][$];
  int               obs_cnt;
  int               obs_idx [64];
  int               obs_cyc [64];
  logic [FRAME-1:0] obs_tx [64];
  logic [FRAME-1:0] obs_busy [64];
  logic [FRAME-1:0] obs_done [64];
  logic [FRAME-1:0] exp_done;

  serial_tx_arbiter #(
    .NREQ(NREQ), .OWNW(OWNW), .BAUD_DIV(BAUD_DIV), .STOP_BITS(STOP_BITS), .LOCK_TMO(LOCK_TMO)
  ) dut (
    .clk100(clk100), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ack(req_ack), .tx(tx), .busy(busy), .locked(locked),
    .owner(owner), .frame_done(frame_done)
  );

  always #5 clk100 = ~clk100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk100);
    #1;
    cycle++;
  endtask

  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] d);
    logic [FRAME-1:0] v;
    logic b;
    v = '0;
    for (int j = 0; j < NBITS; j++) begin
      if (j == 0) b = 1'b0;
      else if (j <= 8) b = d[j-1];
      else b = 1'b1;
      for (int c = 0; c < BAUD_DIV; c++) v[j*BAUD_DIV + c] = b;
    end
    return v;
  endfunction

  function automatic logic pending_any();
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_pending();
    for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_ack(input int limit, output int idx, output int waited, output logic [NREQ-1:0] av);
    idx = -1;
    waited = limit;
    av = '0;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (req_ack != '0) begin
        waited = n;
        av = req_ack;
        for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i]) idx = i;
        break;
      end
    end
  endtask

  task automatic capture_frame(output logic [FRAME-1:0] tv, output logic [FRAME-1:0] bv,
                               output logic [FRAME-1:0] dv);
    for (int s = 0; s < FRAME; s++) begin
      step();
      tv[s] = tx;
      bv[s] = busy;
      dv[s] = frame_done;
    end
  endtask

  task automatic present();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (q[i].size() > 0) begin
        e = q[i][0];
        set_req(i, 1'b1, e[7:0], e[8]);
      end else begin
        set_req(i, 1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  // Offers every queued byte, records each grant and the frame that follows it.
  task automatic run_traffic();
    int idx, waited;
    logic [NREQ-1:0] av;
    obs_cnt = 0;
    present();
    while (pending_any() && obs_cnt < 64) begin
      wait_ack(200, idx, waited, av);
      if (idx < 0) break;
      obs_idx[obs_cnt] = idx;
      obs_cyc[obs_cnt] = cycle;
      void'(q[idx].pop_front());
      present();
      capture_frame(obs_tx[obs_cnt], obs_busy[obs_cnt], obs_done[obs_cnt]);
      obs_cnt++;
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (req_ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", req_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (owner !== '0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    reset = 1'b0;
    step();
    step();
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single_frame();
    int idx, waited;
    logic [NREQ-1:0] av;
    logic [FRAME-1:0] tv, bv, dv;
    apply_reset();
    set_req(0, 1'b1, 8'h55, 1'b1);
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0001 || waited !== 1) begin
      errors++; $display("FAIL single_ack: ack=%b after %0d want 0001 after 1", av, waited);
    end
    checks++; if (busy !== 1'b0 || locked !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL single_ack_state: busy=%b locked=%b owner=%0d want 0 0 0", busy, locked, owner);
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'h55)) begin
      errors++; $display("FAIL single_tx: got %b want %b", tv, frame_bits(8'h55));
    end
    checks++; if (bv !== '1) begin errors++; $display("FAIL single_busy: got %b want all ones", bv); end
    checks++; if (dv !== exp_done) begin errors++; $display("FAIL single_done: got %b want %b", dv, exp_done); end
    step();
    checks++; if (busy !== 1'b0 || tx !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL single_after: busy=%b tx=%b done=%b want 0 1 0", busy, tx, frame_done);
    end
  endtask

  task automatic test_round_robin();
    int exp_i1 [3] = '{1, 2, 3};
    logic [7:0] exp_b1 [3] = '{8'h11, 8'h22, 8'h33};
    int exp_i2 [2] = '{0, 1};
    logic [7:0] exp_b2 [2] = '{8'hA0, 8'hB1};
    apply_reset();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    q[1].push_back({1'b1, 8'h11});
    q[2].push_back({1'b1, 8'h22});
    q[3].push_back({1'b1, 8'h33});
    run_traffic();
    checks++; if (obs_cnt !== 3) begin errors++; $display("FAIL rr1_count: got %0d want 3", obs_cnt); end
    for (int n = 0; n < 3 && n < obs_cnt; n++) begin
      checks++; if (obs_idx[n] !== exp_i1[n]) begin
        errors++; $display("FAIL rr1_order[%0d]: got %0d want %0d", n, obs_idx[n], exp_i1[n]);
      end
      checks++; if (obs_tx[n] !== frame_bits(exp_b1[n])) begin
        errors++; $display("FAIL rr1_tx[%0d]: got %b want %b", n, obs_tx[n], frame_bits(exp_b1[n]));
      end
      if (n > 0) begin
        checks++; if (obs_cyc[n] - obs_cyc[n-1] !== FRAME + 1) begin
          errors++; $display("FAIL rr1_gap[%0d]: got %0d want %0d", n, obs_cyc[n] - obs_cyc[n-1], FRAME + 1);
        end
      end
    end
    q[0].push_back({1'b1, 8'hA0});
    q[1].push_back({1'b1, 8'hB1});
    run_traffic();
    checks++; if (obs_cnt !== 2) begin errors++; $display("FAIL rr2_count: got %0d want 2", obs_cnt); end
    for (int n = 0; n < 2 && n < obs_cnt; n++) begin
      checks++; if (obs_idx[n] !== exp_i2[n] || obs_tx[n] !== frame_bits(exp_b2[n])) begin
        errors++; $display("FAIL rr2[%0d]: req %0d tx %b want req %0d tx %b",
                           n, obs_idx[n], obs_tx[n], exp_i2[n], frame_bits(exp_b2[n]));
      end
    end
  endtask

  task automatic test_message_lock();
    int idx, waited;
    logic [NREQ-1:0] av;
    logic [FRAME-1:0] tv, bv, dv;
    apply_reset();
    set_req(2, 1'b1, 8'h41, 1'b0);
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0100 || locked !== 1'b1 || owner !== 2'd2) begin
      errors++; $display("FAIL lock_first: ack=%b locked=%b owner=%0d want 0100 1 2", av, locked, owner);
    end
    set_req(2, 1'b1, 8'h42, 1'b1);
    set_req(0, 1'b1, 8'h30, 1'b1);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'h41)) begin errors++; $display("FAIL lock_tx41: got %b want %b", tv, frame_bits(8'h41)); end
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0100 || waited !== 1) begin
      errors++; $display("FAIL lock_second: ack=%b after %0d want 0100 after 1", av, waited);
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_release: locked=%b want 0", locked); end
    set_req(2, 1'b0, 8'h00, 1'b0);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'h42)) begin errors++; $display("FAIL lock_tx42: got %b want %b", tv, frame_bits(8'h42)); end
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0001 || waited !== 1) begin
      errors++; $display("FAIL lock_then_req0: ack=%b after %0d want 0001 after 1", av, waited);
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'h30)) begin errors++; $display("FAIL lock_tx30: got %b want %b", tv, frame_bits(8'h30)); end
  endtask

  task automatic test_lock_timeout();
    int idx, waited;
    logic [NREQ-1:0] av;
    logic [FRAME-1:0] tv, bv, dv;
    apply_reset();
    set_req(1, 1'b1, 8'hA1, 1'b0);
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0010 || locked !== 1'b1) begin
      errors++; $display("FAIL tmo_first: ack=%b locked=%b want 0010 1", av, locked);
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    set_req(3, 1'b1, 8'hB3, 1'b1);
    wait_ack(200, idx, waited, av);
    checks++; if (av !== 4'b1000 || waited !== FRAME + LOCK_TMO + 1) begin
      errors++; $display("FAIL tmo_ack: ack=%b after %0d want 1000 after %0d", av, waited, FRAME + LOCK_TMO + 1);
    end
    set_req(3, 1'b0, 8'h00, 1'b0);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'hB3)) begin errors++; $display("FAIL tmo_tx: got %b want %b", tv, frame_bits(8'hB3)); end
  endtask

  task automatic test_reset_mid_frame();
    int idx, waited;
    logic [NREQ-1:0] av;
    logic [FRAME-1:0] tv, bv, dv;
    apply_reset();
    set_req(2, 1'b1, 8'hA5, 1'b0);
    wait_ack(50, idx, waited, av);
    set_req(2, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 1 + 4 * BAUD_DIV; s++) step();
    checks++; if (tx !== 1'b0 || busy !== 1'b1 || locked !== 1'b1 || owner !== 2'd2) begin
      errors++; $display("FAIL midframe_pre: tx=%b busy=%b locked=%b owner=%0d want 0 1 1 2", tx, busy, locked, owner);
    end
    reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL midframe_reset: tx=%b busy=%b locked=%b owner=%0d want 1 0 0 0", tx, busy, locked, owner);
    end
    step();
    step();
    reset = 1'b0;
    step();
    set_req(0, 1'b1, 8'h3C, 1'b1);
    wait_ack(50, idx, waited, av);
    checks++; if (av !== 4'b0001 || waited !== 1) begin
      errors++; $display("FAIL midframe_ack: ack=%b after %0d want 0001 after 1", av, waited);
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    capture_frame(tv, bv, dv);
    checks++; if (tv !== frame_bits(8'h3C) || dv !== exp_done) begin
      errors++; $display("FAIL midframe_tx: tx=%b done=%b want %b %b", tv, dv, frame_bits(8'h3C), exp_done);
    end
  endtask

  task automatic test_valid_pulse();
    int idx, waited, acks, tx_low, busy_hi;
    logic [NREQ-1:0] av;
    apply_reset();
    set_req(1, 1'b1, 8'h77, 1'b1);
    wait_ack(50, idx, waited, av);
    set_req(1, 1'b0, 8'h00, 1'b0);
    acks = 0;
    for (int s = 1; s <= FRAME; s++) begin
      step();
      if (s == 10) set_req(0, 1'b1, 8'h99, 1'b1);
      if (s == 11) set_req(0, 1'b0, 8'h00, 1'b0);
      if (req_ack != '0) acks++;
    end
    tx_low = 0;
    busy_hi = 0;
    for (int s = 0; s < 60; s++) begin
      step();
      if (req_ack != '0) acks++;
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL pulse_acks: got %0d want 0", acks); end
    checks++; if (tx_low !== 0 || busy_hi !== 0) begin
      errors++; $display("FAIL pulse_line: tx-low cycles %0d busy cycles %0d want 0 0", tx_low, busy_hi);
    end
  endtask

  task automatic test_random_traffic();
    int nmsg, len, rr, own, w, c, idx;
    logic lk, lb;
    logic [8:0] e;
    int exp_idx [$];
    logic [7:0] exp_byte [$];
    for (int round = 0; round < 4; round++) begin
      apply_reset();
      exp_idx.delete();
      exp_byte.delete();
      for (int i = 0; i < NREQ; i++) begin
        q[i].delete();
        mq[i].delete();
        nmsg = $urandom_range(0, 2);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            lb = (b == len - 1);
            e = {lb, 8'($urandom)};
            q[i].push_back(e);
            mq[i].push_back(e);
          end
        end
      end
      rr = 0; own = 0; lk = 1'b0;
      while (model_pending()) begin
        w = -1;
        if (lk) begin
          if (mq[own].size() > 0) w = own;
        end else begin
          for (int k = 0; k < NREQ; k++) begin
            c = (rr + k) % NREQ;
            if (w < 0 && mq[c].size() > 0) w = c;
          end
        end
        if (w < 0) break;
        e = mq[w].pop_front();
        exp_idx.push_back(w);
        exp_byte.push_back(e[7:0]);
        lk = ~e[8];
        own = w;
        rr = (w + 1) % NREQ;
      end
      run_traffic();
      checks++; if (obs_cnt !== exp_idx.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", round, obs_cnt, exp_idx.size());
      end
      for (int n = 0; n < obs_cnt && n < exp_idx.size(); n++) begin
        idx = exp_idx[n];
        checks++; if (obs_idx[n] !== idx) begin
          errors++; $display("FAIL rand%0d_order[%0d]: got %0d want %0d", round, n, obs_idx[n], idx);
        end
        checks++; if (obs_tx[n] !== frame_bits(exp_byte[n]) || obs_busy[n] !== '1 || obs_done[n] !== exp_done) begin
          errors++; $display("FAIL rand%0d_frame[%0d]: tx=%b busy=%b done=%b want tx=%b", round, n,
                             obs_tx[n], obs_busy[n], obs_done[n], frame_bits(exp_byte[n]));
        end
        if (n > 0) begin
          checks++; if (obs_cyc[n] - obs_cyc[n-1] !== FRAME + 1) begin
            errors++; $display("FAIL rand%0d_gap[%0d]: got %0d want %0d", round, n, obs_cyc[n] - obs_cyc[n-1], FRAME + 1);
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    exp_done  = '0;
    exp_done[FRAME-1] = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_message_lock();
    test_lock_timeout();
    test_reset_mid_frame();
    test_valid_pulse();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
